// File: rtl/riscv_ctrl_pkg.sv
// Shared control definitions: FSM state encodings, RV32I opcode constants,
// ALU class codes and write-back select codes (riscv_isa_defines section).
package riscv_ctrl_pkg;

    typedef enum logic [6:0] {
        ST_IDLE   = 7'b0000001,
        ST_FETCH  = 7'b0000010,
        ST_DECODE = 7'b0000100,
        ST_EX     = 7'b0001000,
        ST_MEM    = 7'b0010000,
        ST_WB     = 7'b0100000,
        ST_TRAP   = 7'b1000000
    } state_e;

    // riscv_isa_defines
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [1:0] ALU_CLS_ADD   = 2'b00;
    localparam logic [1:0] ALU_CLS_ARITH = 2'b01;
    localparam logic [1:0] ALU_CLS_BR    = 2'b10;
    localparam logic [1:0] ALU_CLS_LUI   = 2'b11;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    function automatic logic [5:0] alu_sel(input logic [1:0] cls,
                                           input logic       f7b,
                                           input logic [2:0] f3);
        return {cls, f7b, f3};
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// Combinational instruction decode for the multi-cycle controller:
// ALU class, funct7 modifier bit, write-back/memory attributes and legality.
module mc_ctrl_dec
    import riscv_ctrl_pkg::*;
(
    input  logic [31:0] i_ir,
    output logic [1:0]  o_cls,
    output logic        o_f7b,
    output logic        o_wr_rd,
    output logic        o_is_mem,
    output logic        o_is_store,
    output logic        o_is_branch,
    output logic        o_is_jump,
    output logic        o_src_imm,
    output logic [1:0]  o_wb_sel,
    output logic        o_legal
);

    logic [6:0] w_opc;
    logic [2:0] w_f3;
    logic       w_opc_ok;
    logic       w_unused;

    assign w_opc    = i_ir[6:0];
    assign w_f3     = i_ir[14:12];
    assign w_unused = ^{i_ir[31], i_ir[29:15], i_ir[11:7]};

    always_comb begin
        o_cls       = ALU_CLS_ADD;
        o_f7b       = 1'b0;
        o_wr_rd     = 1'b0;
        o_is_mem    = 1'b0;
        o_is_store  = 1'b0;
        o_is_branch = 1'b0;
        o_is_jump   = 1'b0;
        o_src_imm   = 1'b0;
        o_wb_sel    = WB_ALU;
        w_opc_ok    = 1'b1;
        case (w_opc)
            OPC_LUI: begin
                o_cls     = ALU_CLS_LUI;
                o_wr_rd   = 1'b1;
                o_src_imm = 1'b1;
            end
            OPC_AUIPC: begin
                o_wr_rd   = 1'b1;
                o_src_imm = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                o_wr_rd   = 1'b1;
                o_src_imm = 1'b1;
                o_is_jump = 1'b1;
                o_wb_sel  = WB_PC4;
            end
            OPC_BRANCH: begin
                o_cls       = ALU_CLS_BR;
                o_is_branch = 1'b1;
            end
            OPC_LOAD: begin
                o_wr_rd   = 1'b1;
                o_src_imm = 1'b1;
                o_is_mem  = 1'b1;
                o_wb_sel  = WB_MEM;
            end
            OPC_STORE: begin
                o_src_imm  = 1'b1;
                o_is_mem   = 1'b1;
                o_is_store = 1'b1;
            end
            OPC_OPIMM: begin
                // Only the shift-right immediate form carries the arith/logical bit.
                o_cls     = ALU_CLS_ARITH;
                o_wr_rd   = 1'b1;
                o_src_imm = 1'b1;
                o_f7b     = (w_f3 == 3'b101) && i_ir[30];
            end
            OPC_OP: begin
                o_cls   = ALU_CLS_ARITH;
                o_wr_rd = 1'b1;
                o_f7b   = i_ir[30];
            end
            default: w_opc_ok = 1'b0;
        endcase
        o_legal = w_opc_ok && (i_ir[1:0] == 2'b11);
    end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/write-back
// sequencing with handshake timeouts; all control outputs are registered.
module mc_ctrl
    import riscv_ctrl_pkg::*;
#(
    parameter int unsigned ALU_S_W = 6,
    parameter int unsigned TO_CYC  = 16
) (
    input  logic               CLK,
    input  logic               RES_N,
    input  logic [31:0]        INSTR,
    input  logic               INSTR_VALID,
    output logic               INSTR_REQ,
    input  logic               DATA_VALID,
    output logic               DATA_REQ,
    output logic               MEM_WE,
    input  logic               BR_TAKEN,
    output logic               REG_WRITE,
    output logic               PC_WRITE,
    output logic               BRANCH,
    output logic               JUMP,
    output logic               ALU_SRC_IMM,
    output logic [1:0]         WB_SEL,
    output logic [ALU_S_W-1:0] ALU_S,
    output logic               ILLEGAL,
    output logic               BUS_ERR,
    output logic [31:0]        IR
);

    localparam int unsigned      CNT_W    = $clog2(TO_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_CYC - 1);

    state_e             r_state;
    logic [31:0]        r_ir;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_instr_req, r_data_req, r_mem_we;
    logic               r_reg_write, r_pc_write, r_branch, r_jump, r_src_imm;
    logic [1:0]         r_wb_sel;
    logic [ALU_S_W-1:0] r_alu_s;
    logic               r_illegal, r_bus_err;

    logic [1:0] w_cls;
    logic       w_f7b, w_wr_rd, w_is_mem, w_is_store, w_is_branch, w_is_jump;
    logic       w_src_imm, w_legal, w_cnt_last, w_rd_nz;
    logic [1:0] w_wb_sel;

    mc_ctrl_dec u_dec (
        .i_ir        (r_ir),
        .o_cls       (w_cls),
        .o_f7b       (w_f7b),
        .o_wr_rd     (w_wr_rd),
        .o_is_mem    (w_is_mem),
        .o_is_store  (w_is_store),
        .o_is_branch (w_is_branch),
        .o_is_jump   (w_is_jump),
        .o_src_imm   (w_src_imm),
        .o_wb_sel    (w_wb_sel),
        .o_legal     (w_legal)
    );

    assign w_cnt_last = (r_cnt == CNT_LAST);
    assign w_rd_nz    = |r_ir[11:7];

    // Outputs are loaded on the edge that enters a state, so they are valid
    // for exactly the cycles spent in that state and default back to 0.
    always_ff @(posedge CLK or negedge RES_N) begin
        if (!RES_N) begin
            r_state     <= ST_IDLE;
            r_ir        <= '0;
            r_cnt       <= '0;
            r_instr_req <= 1'b0;
            r_data_req  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_reg_write <= 1'b0;
            r_pc_write  <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_src_imm   <= 1'b0;
            r_wb_sel    <= '0;
            r_alu_s     <= '0;
            r_illegal   <= 1'b0;
            r_bus_err   <= 1'b0;
        end else begin
            r_instr_req <= 1'b0;
            r_data_req  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_reg_write <= 1'b0;
            r_pc_write  <= 1'b0;
            r_branch    <= 1'b0;
            r_jump      <= 1'b0;
            r_src_imm   <= 1'b0;
            r_wb_sel    <= '0;
            r_alu_s     <= '0;
            r_illegal   <= 1'b0;
            r_bus_err   <= 1'b0;
            case (r_state)
                ST_IDLE, ST_WB, ST_TRAP: begin
                    r_state     <= ST_FETCH;
                    r_cnt       <= '0;
                    r_instr_req <= 1'b1;
                end
                ST_FETCH: begin
                    if (INSTR_VALID) begin
                        r_ir    <= INSTR;
                        r_state <= ST_DECODE;
                    end else if (w_cnt_last) begin
                        r_state   <= ST_TRAP;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt       <= r_cnt + 1'b1;
                        r_instr_req <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (w_legal) begin
                        r_state   <= ST_EX;
                        r_alu_s   <= ALU_S_W'(alu_sel(w_cls, w_f7b, r_ir[14:12]));
                        r_src_imm <= w_src_imm;
                    end else begin
                        r_state   <= ST_TRAP;
                        r_illegal <= 1'b1;
                    end
                end
                ST_EX: begin
                    if (w_is_mem) begin
                        r_state    <= ST_MEM;
                        r_cnt      <= '0;
                        r_data_req <= 1'b1;
                        r_mem_we   <= w_is_store;
                    end else begin
                        r_state     <= ST_WB;
                        r_pc_write  <= 1'b1;
                        r_reg_write <= w_wr_rd && w_rd_nz;
                        r_wb_sel    <= w_wb_sel;
                        r_branch    <= w_is_branch && BR_TAKEN;
                        r_jump      <= w_is_jump;
                    end
                end
                ST_MEM: begin
                    if (DATA_VALID) begin
                        r_state     <= ST_WB;
                        r_pc_write  <= 1'b1;
                        r_reg_write <= w_wr_rd && w_rd_nz;
                        r_wb_sel    <= w_wb_sel;
                    end else if (w_cnt_last) begin
                        r_state   <= ST_TRAP;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_cnt      <= r_cnt + 1'b1;
                        r_data_req <= 1'b1;
                        r_mem_we   <= w_is_store;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign INSTR_REQ   = r_instr_req;
    assign DATA_REQ    = r_data_req;
    assign MEM_WE      = r_mem_we;
    assign REG_WRITE   = r_reg_write;
    assign PC_WRITE    = r_pc_write;
    assign BRANCH      = r_branch;
    assign JUMP        = r_jump;
    assign ALU_SRC_IMM = r_src_imm;
    assign WB_SEL      = r_wb_sel;
    assign ALU_S       = r_alu_s;
    assign ILLEGAL     = r_illegal;
    assign BUS_ERR     = r_bus_err;
    assign IR          = r_ir;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl; expected output words are
// hand-computed per state from the RV32I encodings of each test instruction.
module tb_mc_ctrl;

    logic        CLK = 1'b0;
    logic        RES_N = 1'b0;
    logic [31:0] INSTR = '0;
    logic        INSTR_VALID = 1'b0;
    logic        DATA_VALID = 1'b0;
    logic        BR_TAKEN = 1'b0;
    logic        INSTR_REQ, DATA_REQ, MEM_WE, REG_WRITE, PC_WRITE;
    logic        BRANCH, JUMP, ALU_SRC_IMM, ILLEGAL, BUS_ERR;
    logic [1:0]  WB_SEL;
    logic [5:0]  ALU_S;
    logic [31:0] IR;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    mc_ctrl #(.ALU_S_W(6), .TO_CYC(16)) dut (
        .CLK         (CLK),
        .RES_N       (RES_N),
        .INSTR       (INSTR),
        .INSTR_VALID (INSTR_VALID),
        .INSTR_REQ   (INSTR_REQ),
        .DATA_VALID  (DATA_VALID),
        .DATA_REQ    (DATA_REQ),
        .MEM_WE      (MEM_WE),
        .BR_TAKEN    (BR_TAKEN),
        .REG_WRITE   (REG_WRITE),
        .PC_WRITE    (PC_WRITE),
        .BRANCH      (BRANCH),
        .JUMP        (JUMP),
        .ALU_SRC_IMM (ALU_SRC_IMM),
        .WB_SEL      (WB_SEL),
        .ALU_S       (ALU_S),
        .ILLEGAL     (ILLEGAL),
        .BUS_ERR     (BUS_ERR),
        .IR          (IR)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Output word layout: {ireq,dreq,we,rw,pcw,br,jmp,imm,wbsel[1:0],alus[5:0],ill,berr}
    function automatic logic [31:0] mk(input logic ireq, input logic dreq, input logic we,
                                       input logic rw, input logic pcw, input logic br,
                                       input logic jmp, input logic imm, input logic [1:0] wbs,
                                       input logic [5:0] alus, input logic ill, input logic berr);
        return {14'b0, ireq, dreq, we, rw, pcw, br, jmp, imm, wbs, alus, ill, berr};
    endfunction

    function automatic logic [31:0] outs();
        return {14'b0, INSTR_REQ, DATA_REQ, MEM_WE, REG_WRITE, PC_WRITE, BRANCH, JUMP,
                ALU_SRC_IMM, WB_SEL, ALU_S, ILLEGAL, BUS_ERR};
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic cyc(input string tag, input logic [31:0] exp);
        @(posedge CLK);
        #1;
        check_eq(tag, outs(), exp);
    endtask

    // Entered while in FETCH; leaves the DUT in DECODE with IR checked.
    task automatic do_fetch(input logic [31:0] ins, input int unsigned waits);
        for (int unsigned i = 0; i < waits; i++) begin
            INSTR_VALID = 1'b0;
            cyc("fetch_wait", mk(1,0,0,0,0,0,0,0,2'd0,6'd0,0,0));
        end
        INSTR = ins;
        INSTR_VALID = 1'b1;
        cyc("decode", '0);
        INSTR_VALID = 1'b0;
        INSTR = 32'hDEADBEEF;
        check_eq("ir_latch", IR, ins);
    endtask

    // Entered while in EX of a memory op; checks 1+waits MEM cycles then WB.
    task automatic do_mem(input string tag, input logic [31:0] e_mem,
                          input int unsigned waits, input logic [31:0] e_wb);
        DATA_VALID = 1'b0;
        cyc(tag, e_mem);
        for (int unsigned i = 0; i < waits; i++) cyc(tag, e_mem);
        DATA_VALID = 1'b1;
        cyc("mem_wb", e_wb);
        DATA_VALID = 1'b0;
    endtask

    localparam logic [31:0] E_FETCH = 32'h0002_0000;

    initial begin
        // Reset state
        repeat (2) @(posedge CLK);
        #1;
        check_eq("reset_outs", outs(), '0);
        check_eq("reset_ir", IR, '0);
        RES_N = 1'b1;
        check_eq("idle_outs", outs(), '0);
        cyc("fetch_after_reset", E_FETCH);

        // ADDI x1,x0,5 zero-wait
        do_fetch(32'h00500093, 0);
        cyc("addi_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b010000,0,0));
        cyc("addi_wb", mk(0,0,0,1,1,0,0,0,2'd0,6'd0,0,0));
        cyc("addi_fetch", E_FETCH);

        // LW x2,0(x1) with fetch wait 2 and data valid on 4th MEM cycle
        do_fetch(32'h0000A103, 2);
        cyc("lw_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b000010,0,0));
        do_mem("lw_mem", mk(0,1,0,0,0,0,0,0,2'd0,6'd0,0,0), 3,
               mk(0,0,0,1,1,0,0,0,2'd1,6'd0,0,0));
        cyc("lw_fetch", E_FETCH);

        // SW x2,4(x1); stray INSTR_VALID during MEM must not change IR
        do_fetch(32'h0020A223, 0);
        cyc("sw_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b000010,0,0));
        INSTR_VALID = 1'b1;
        do_mem("sw_mem", mk(0,1,1,0,0,0,0,0,2'd0,6'd0,0,0), 1,
               mk(0,0,0,0,1,0,0,0,2'd0,6'd0,0,0));
        INSTR_VALID = 1'b0;
        check_eq("sw_ir_hold", IR, 32'h0020A223);
        cyc("sw_fetch", E_FETCH);

        // BEQ x0,x0,8 taken
        do_fetch(32'h00000463, 0);
        BR_TAKEN = 1'b1;
        cyc("beq_ex", mk(0,0,0,0,0,0,0,0,2'd0,6'b100000,0,0));
        cyc("beq_wb", mk(0,0,0,0,1,1,0,0,2'd0,6'd0,0,0));
        cyc("beq_fetch", E_FETCH);

        // BEQ not taken
        do_fetch(32'h00000463, 0);
        BR_TAKEN = 1'b0;
        cyc("beqnt_ex", mk(0,0,0,0,0,0,0,0,2'd0,6'b100000,0,0));
        cyc("beqnt_wb", mk(0,0,0,0,1,0,0,0,2'd0,6'd0,0,0));
        cyc("beqnt_fetch", E_FETCH);

        // SUB x3,x1,x2 (f7b from IR[30], register operand)
        do_fetch(32'h402081B3, 0);
        cyc("sub_ex", mk(0,0,0,0,0,0,0,0,2'd0,6'b011000,0,0));
        cyc("sub_wb", mk(0,0,0,1,1,0,0,0,2'd0,6'd0,0,0));
        cyc("sub_fetch", E_FETCH);

        // ADDI x0,x0,0 (rd=0, no register write)
        do_fetch(32'h00000013, 0);
        cyc("nop_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b010000,0,0));
        cyc("nop_wb", mk(0,0,0,0,1,0,0,0,2'd0,6'd0,0,0));
        cyc("nop_fetch", E_FETCH);

        // JAL x1,0
        do_fetch(32'h000000EF, 0);
        cyc("jal_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b000000,0,0));
        cyc("jal_wb", mk(0,0,0,1,1,0,1,0,2'd2,6'd0,0,0));
        cyc("jal_fetch", E_FETCH);

        // Illegal instruction
        do_fetch(32'hFFFFFFFF, 0);
        cyc("ill_trap", mk(0,0,0,0,0,0,0,0,2'd0,6'd0,1,0));
        cyc("ill_fetch", E_FETCH);

        // LW with DATA_VALID withheld: 16 MEM cycles then BUS_ERR
        do_fetch(32'h0000A103, 0);
        cyc("lwto_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b000010,0,0));
        DATA_VALID = 1'b0;
        for (int unsigned i = 0; i < 16; i++)
            cyc("lwto_mem", mk(0,1,0,0,0,0,0,0,2'd0,6'd0,0,0));
        cyc("lwto_trap", mk(0,0,0,0,0,0,0,0,2'd0,6'd0,0,1));
        cyc("lwto_fetch", E_FETCH);

        // LW with DATA_VALID on the 16th MEM cycle: success
        do_fetch(32'h0000A103, 0);
        cyc("lw16_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b000010,0,0));
        do_mem("lw16_mem", mk(0,1,0,0,0,0,0,0,2'd0,6'd0,0,0), 15,
               mk(0,0,0,1,1,0,0,0,2'd1,6'd0,0,0));
        cyc("lw16_fetch", E_FETCH);

        // Instruction fetch timeout
        for (int unsigned i = 0; i < 15; i++)
            cyc("fto_wait", E_FETCH);
        cyc("fto_trap", mk(0,0,0,0,0,0,0,0,2'd0,6'd0,0,1));
        cyc("fto_fetch", E_FETCH);

        // Reset asserted mid-MEM
        do_fetch(32'h0000A103, 0);
        cyc("rst_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b000010,0,0));
        cyc("rst_mem", mk(0,1,0,0,0,0,0,0,2'd0,6'd0,0,0));
        cyc("rst_mem2", mk(0,1,0,0,0,0,0,0,2'd0,6'd0,0,0));
        #2;
        RES_N = 1'b0;
        #1;
        check_eq("rst_async_outs", outs(), '0);
        check_eq("rst_async_ir", IR, '0);
        DATA_VALID = 1'b1;
        @(posedge CLK);
        #1;
        RES_N = 1'b1;
        check_eq("rst_idle", outs(), '0);
        cyc("rst_fetch", E_FETCH);
        cyc("rst_late_dvalid", E_FETCH);
        DATA_VALID = 1'b0;
        do_fetch(32'h00500093, 0);
        cyc("post_rst_ex", mk(0,0,0,0,0,0,0,1,2'd0,6'b010000,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
